vending_input_conditioner: RTL
==============================

// Module: vending_input_conditioner
// PURPOSE
//   Upstream stage of the vending-machine FSM. Conditions the raw pad inputs
//   (coin, accept, Moore-reset button, Mealy-reset button) before the FSM sees them.
//   Per channel: synchronize, debounce, then produce a clean level and 1-cycle edge pulses.
//   Coin pulses are rate-limited and buffered one deep so the FSM never gets two
//   coins closer than MIN_GAP cycles.
// PARAMETERS
//   N_CH            4   number of conditioned input channels
//   SYNC_STAGES     2   synchronizer flops per channel (>=2)
//   DEBOUNCE_CYCLES 16  consecutive stable cycles needed to accept a new level (>=2)
//   MIN_GAP         8   minimum clocks between coin_pulse assertions (>=2)
// PORTS
//   clk          in   1     system clock
//   rst          in   1     synchronous reset, active-high
//   ena          in   1     design enable; 0 = freeze all state
//   raw_in       in   N_CH  asynchronous pad inputs, index per vending_pkg
//   level_out    out  N_CH  debounced stable level per channel
//   rise_pulse   out  N_CH  1-cycle pulse on each debounced 0->1
//   fall_pulse   out  N_CH  1-cycle pulse on each debounced 1->0
//   coin_pulse   out  1     rate-limited coin strobe to the FSM "m" input
//   coin_overrun out  1     1-cycle flag: coin edge dropped (pending slot already full)
// BEHAVIOUR
//   Reset (rst=1 at clk edge): sync flops, stable levels, counters, pending, gap -> 0;
//     all outputs 0 the cycle after. Reset mid-debounce or mid-gap discards that work.
//   ena=0: every register holds its value; rise/fall/coin_pulse/coin_overrun forced 0.
//   Sync: raw_in[i] -> SYNC_STAGES-flop chain; s[i] = last stage.
//   Debounce per channel: cnt (width $clog2(DEBOUNCE_CYCLES)).
//     s==stable -> cnt<=0.
//     s!=stable and cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1.
//     s!=stable and cnt==DEBOUNCE_CYCLES-1 -> stable<=s, cnt<=0.
//     Any glitch back to stable before terminal count restarts cnt at 0.
//   Latency: a clean raw step seen first at edge k appears on level_out after
//     edge k+SYNC_STAGES+DEBOUNCE_CYCLES-1 (i.e. SYNC_STAGES+DEBOUNCE_CYCLES edges total).
//   rise/fall_pulse: registered, high exactly the cycle level_out shows the new value.
//   Coin gate (channel CH_COIN, source rise_pulse[CH_COIN] as event e):
//     gap counter g; g!=0 -> g<=g-1 each enabled cycle.
//     Emit when g==0 and (e or pending): coin_pulse<=1, g<=MIN_GAP-1, pending<=0.
//       If pending and e in same cycle: emit the pending one; e becomes pending.
//     e while g!=0: pending==0 -> pending<=1; pending==1 -> drop e, coin_overrun<=1.
//   Resulting invariant: coin_pulse assertions are >= MIN_GAP cycles apart; at most
//     one coin is ever buffered; no coin is lost without coin_overrun.
//   Other channels bypass the gate; FSM uses level_out[CH_RST_*] as reset levels and
//     rise_pulse[CH_ACCEPT] as the accept strobe.
// STRUCTURE
//   vending_pkg: localparams CH_COIN=0, CH_ACCEPT=1, CH_RST_MOORE=2, CH_RST_MEALY=3,
//     N_CH_DEFAULT=4; shared with fsm_top and the TT wrapper.
//   Sub-module input_debounce_ch (one channel: sync chain + counter + edge pulses),
//     instantiated N_CH times by generate loop; coin gate lives in the top module.
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, MIN_GAP=8)
//   1 rst=1 for 3 cycles, raw_in=4'hF -> all outputs 0; released -> level_out=4'hF
//     after 6 edges, rise_pulse=4'hF exactly one cycle, coin_pulse once.
//   2 raw_in[1] toggles every 2 cycles for 40 cycles -> level_out[1] stays 0,
//     no rise/fall pulses; then held 1 -> rises after 6 edges.
//   3 Three clean coin presses, debounced rises 2 cycles apart -> coin_pulse at t,
//     t+8, with the third coin_overrun=1 for 1 cycle; exactly 2 coin_pulse total.
//   4 Two coin rises 10 cycles apart -> two coin_pulse, 10 cycles apart, no overrun.
//   5 Coin pending, rst=1 asserted at gap count 3 -> pending cleared, no coin_pulse
//     after reset release while raw stays 0.
//   6 ena=0 during debounce count 2 for 5 cycles, raw held -> counter frozen,
//     level_out rises 2 enabled cycles after ena returns to 1.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared channel map and sizing helpers for the vending-machine input path.
package vending_pkg;

  localparam int unsigned N_CH_DEFAULT = 4;

  localparam int unsigned CH_COIN      = 0;
  localparam int unsigned CH_ACCEPT    = 1;
  localparam int unsigned CH_RST_MOORE = 2;
  localparam int unsigned CH_RST_MEALY = 3;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/input_debounce_ch.sv
// One pad channel: synchronizer chain, stability counter, and registered edge pulses.
module input_debounce_ch
  import vending_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else if (ena) begin
      sync <= {sync[SYNC_STAGES-2:0], raw};
      rise <= 1'b0;
      fall <= 1'b0;
      if (s == level) begin
        cnt <= '0;
      end else if (cnt != CNT_LAST) begin
        cnt <= cnt + CNT_W'(1);
      end else begin
        level <= s;
        cnt   <= '0;
        rise  <= s;
        fall  <= ~s;
      end
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
    end
  end

endmodule

// File: rtl/vending_input_conditioner.sv
// Conditions raw vending pads into clean levels/edges and a rate-limited coin strobe.
module vending_input_conditioner
  import vending_pkg::*;
#(
  parameter int unsigned N_CH            = N_CH_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MIN_GAP         = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic [N_CH-1:0] raw_in,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] rise_pulse,
  output logic [N_CH-1:0] fall_pulse,
  output logic            coin_pulse,
  output logic            coin_overrun
);

  localparam int unsigned GAP_W = cnt_width(MIN_GAP);
  localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_GAP - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    input_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .ena   (ena),
      .raw   (raw_in[i]),
      .level (level_out[i]),
      .rise  (rise_pulse[i]),
      .fall  (fall_pulse[i])
    );
  end

  logic [GAP_W-1:0] gap;
  logic             pending;
  logic             coin_evt;

  assign coin_evt = rise_pulse[CH_COIN];

  // Coin gate: one-deep buffer; a pending coin always goes out ahead of a fresh one.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap          <= '0;
      pending      <= 1'b0;
      coin_pulse   <= 1'b0;
      coin_overrun <= 1'b0;
    end else if (!ena) begin
      coin_pulse   <= 1'b0;
      coin_overrun <= 1'b0;
    end else begin
      coin_pulse   <= 1'b0;
      coin_overrun <= 1'b0;
      if (gap != '0) begin
        gap <= gap - GAP_W'(1);
      end
      if ((gap == '0) && (coin_evt || pending)) begin
        coin_pulse <= 1'b1;
        gap        <= GAP_RELOAD;
        pending    <= pending & coin_evt;
      end else if (coin_evt) begin
        if (!pending) begin
          pending <= 1'b1;
        end else begin
          coin_overrun <= 1'b1;
        end
      end
    end
  end

endmodule
